// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - ID stage: decode, load-use stall, jump/branch-on-zero resolve, halt
module instr_decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] ins,
    input  logic        zero_flag,
    output logic        stall,
    output logic        stall_pm,
    output logic        pc_mux_sel,
    output logic [7:0]  jmp_loc,
    output logic        ex_valid,
    output logic [4:0]  ex_opcode,
    output logic [4:0]  ex_dest,
    output logic [4:0]  ex_src1,
    output logic [4:0]  ex_src2,
    output logic [7:0]  ex_imm,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH, S_HALT} state_t;

    state_t      state_q, state_d;
    logic        ex_valid_q, ex_valid_d;
    logic [4:0]  ex_opcode_q, ex_opcode_d;
    logic [4:0]  ex_dest_q, ex_dest_d;
    logic [4:0]  ex_src1_q, ex_src1_d;
    logic [4:0]  ex_src2_q, ex_src2_d;
    logic [7:0]  ex_imm_q, ex_imm_d;
    logic        ex_reg_write_q, ex_reg_write_d;
    logic        ex_mem_read_q, ex_mem_read_d;
    logic        ex_mem_write_q, ex_mem_write_d;
    logic        halted_q, halted_d;
    logic        illegal_q, illegal_d;

    logic [4:0]  opcode, dest, src1, src2;
    logic        is_nop, is_rr, is_ri, is_ld, is_st, is_jmp, is_bz, is_halt, is_illegal;
    logic        rd_src1, rd_src2, hazard;
    logic        stall_c, pc_mux_c;

    assign opcode = ins[19:15];
    assign dest   = ins[14:10];
    assign src1   = ins[9:5];
    assign src2   = ins[4:0];

    always_comb begin
        is_nop     = (opcode == 5'b00000);
        is_rr      = (opcode >= 5'b00001) && (opcode <= 5'b01111);
        is_ri      = (opcode >= 5'b10000) && (opcode <= 5'b10011);
        is_ld      = (opcode == 5'b10100);
        is_st      = (opcode == 5'b10101);
        is_jmp     = (opcode == 5'b11000);
        is_bz      = (opcode == 5'b11001);
        is_halt    = (opcode == 5'b11111);
        is_illegal = !(is_nop || is_rr || is_ri || is_ld || is_st || is_jmp || is_bz || is_halt);
        rd_src1    = is_rr || is_ri || is_st;
        rd_src2    = is_rr;
        // r0 is hard-wired, so neither a r0 load nor a r0 read can create a dependency
        hazard     = ex_valid_q && ex_mem_read_q && (ex_dest_q != 5'd0) &&
                     ((rd_src1 && (src1 == ex_dest_q)) || (rd_src2 && (src2 == ex_dest_q)));
    end

    always_comb begin
        state_d        = state_q;
        ex_valid_d     = 1'b0;
        ex_opcode_d    = 5'd0;
        ex_dest_d      = 5'd0;
        ex_src1_d      = 5'd0;
        ex_src2_d      = 5'd0;
        ex_imm_d       = 8'd0;
        ex_reg_write_d = 1'b0;
        ex_mem_read_d  = 1'b0;
        ex_mem_write_d = 1'b0;
        illegal_d      = illegal_q;
        stall_c        = 1'b0;
        pc_mux_c       = 1'b0;
        case (state_q)
            S_HALT:  stall_c = 1'b1;
            S_FLUSH: state_d = S_RUN;
            default: begin
                state_d = S_RUN;
                if (is_illegal)
                    illegal_d = 1'b1;
                if (hazard) begin
                    stall_c = 1'b1;
                    state_d = S_STALL;
                end else if (is_jmp || (is_bz && zero_flag)) begin
                    pc_mux_c = 1'b1;
                    state_d  = S_FLUSH;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_rr || is_ri || is_ld || is_st) begin
                    ex_valid_d     = 1'b1;
                    ex_opcode_d    = opcode;
                    ex_dest_d      = dest;
                    ex_src1_d      = src1;
                    ex_src2_d      = src2;
                    ex_imm_d       = ins[7:0];
                    ex_reg_write_d = is_rr || is_ri || is_ld;
                    ex_mem_read_d  = is_ld;
                    ex_mem_write_d = is_st;
                end
            end
        endcase
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_RUN;
            ex_valid_q     <= 1'b0;
            ex_opcode_q    <= 5'd0;
            ex_dest_q      <= 5'd0;
            ex_src1_q      <= 5'd0;
            ex_src2_q      <= 5'd0;
            ex_imm_q       <= 8'd0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            halted_q       <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ex_valid_q     <= ex_valid_d;
            ex_opcode_q    <= ex_opcode_d;
            ex_dest_q      <= ex_dest_d;
            ex_src1_q      <= ex_src1_d;
            ex_src2_q      <= ex_src2_d;
            ex_imm_q       <= ex_imm_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d;
            halted_q       <= halted_d;
            illegal_q      <= illegal_d;
        end
    end

    assign stall        = stall_c && !reset;
    assign stall_pm     = stall_c && !reset;
    assign pc_mux_sel   = pc_mux_c && !reset;
    assign jmp_loc      = ins[7:0];
    assign ex_valid     = ex_valid_q;
    assign ex_opcode    = ex_opcode_q;
    assign ex_dest      = ex_dest_q;
    assign ex_src1      = ex_src1_q;
    assign ex_src2      = ex_src2_q;
    assign ex_imm       = ex_imm_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_mem_write = ex_mem_write_q;
    assign halted       = halted_q;
    assign illegal      = illegal_q;

endmodule
